// File: rtl/cl_memdut_scrubber.sv
`timescale 1ns/1ps
// cl_memdut_scrubber
// Zero-fill scrubber for the memdut DDR path. Walks a fixed address window
// with one AXI write burst in flight at a time (AW, then W beats, then B),
// and reports progress (address, state, done, error count) to the scrub
// control bus. Only the AXI write channels are driven. Every output comes
// straight from a flop; the next value is derived from the next FSM state so
// that outputs change on the same edge as the state.
module cl_memdut_scrubber #(
    parameter logic [63:0] MEM_BASE  = 64'h0,
    parameter logic [63:0] MEM_SIZE  = 64'h4_0000_0000,
    parameter int unsigned BURST_LEN = 64,
    parameter logic [15:0] SCRB_ID   = 16'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    // scrub control bus
    input  logic         scrb_enable,
    output logic [63:0]  scrb_addr,
    output logic [2:0]   scrb_state,
    output logic         scrb_done,
    output logic [15:0]  scrb_err_cnt,
    // AXI write address channel
    output logic [15:0]  awid,
    output logic [63:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic         awvalid,
    input  logic         awready,
    // AXI write data channel
    output logic [15:0]  wid,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // AXI write response channel
    input  logic [15:0]  bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    // 64-byte beats; a burst never crosses a 4 KB boundary given an aligned base
    localparam logic [63:0] BURST_BYTES = 64'(BURST_LEN) * 64'd64;
    localparam logic [63:0] END_ADDR    = MEM_BASE + MEM_SIZE;
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [7:0]  AWLEN_VAL   = 8'(BURST_LEN - 1);
    localparam logic [2:0]  AWSIZE_64B  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [15:0]   err_q, err_d;
    logic [7:0]    beat_q, beat_d;
    logic [63:0]   addr_inc;

    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          wlast_q, wlast_d;
    logic          bready_q, bready_d;
    logic          done_q, done_d;
    logic [63:0]   awaddr_q, awaddr_d;
    logic [7:0]    awlen_q, awlen_d;
    logic [2:0]    awsize_q, awsize_d;
    logic [15:0]   awid_q, awid_d;
    logic [15:0]   wid_q, wid_d;
    logic [63:0]   wstrb_q, wstrb_d;

    logic          aw_hs, w_hs, b_hs;

    // Responses are matched by order, not by ID: only one burst is ever open
    logic          unused_bid;
    assign unused_bid = ^bid;

    assign aw_hs    = awvalid_q & awready;
    assign w_hs     = wvalid_q & wready;
    assign b_hs     = bready_q & bvalid;
    assign addr_inc = addr_q + BURST_BYTES;

    // Next-state logic: burst sequencing, address walk and error counting
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (scrb_enable) begin
                    addr_d  = MEM_BASE;
                    err_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_hs) begin
                    beat_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                // Abort is only honoured here, once the open burst is fully closed
                if (b_hs) begin
                    if ((bresp != 2'b00) && (err_q != 16'hFFFF)) begin
                        err_d = err_q + 16'd1;
                    end
                    addr_d = addr_inc;
                    if (addr_inc == END_ADDR) begin
                        state_d = S_DONE;
                    end else if (scrb_enable) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                if (!scrb_enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values follow the next state so they switch on the same edge
    always_comb begin
        awvalid_d = (state_d == S_ADDR);
        wvalid_d  = (state_d == S_DATA);
        bready_d  = (state_d == S_RESP);
        done_d    = (state_d == S_DONE);
        wlast_d   = (state_d == S_DATA) && (beat_d == LAST_BEAT);
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awid_d    = awid_q;
        wid_d     = wid_q;
        wstrb_d   = wstrb_q;
        // addr_d is constant throughout ADDR, so AW payload holds under stall
        if (state_d == S_ADDR) begin
            awaddr_d = addr_d;
            awlen_d  = AWLEN_VAL;
            awsize_d = AWSIZE_64B;
            awid_d   = SCRB_ID;
        end
        if (state_d == S_DATA) begin
            wid_d   = SCRB_ID;
            wstrb_d = '1;
        end
    end

    // FSM and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            err_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
        end
    end

    // AXI channel and status output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awid_q    <= '0;
            wid_q     <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awid_q    <= awid_d;
            wid_q     <= wid_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign scrb_addr    = addr_q;
    assign scrb_state   = state_q;
    assign scrb_done    = done_q;
    assign scrb_err_cnt = err_q;

    assign awid    = awid_q;
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awvalid = awvalid_q;

    // Scrub payload is always zero, in and out of reset
    assign wdata  = '0;
    assign wid    = wid_q;
    assign wstrb  = wstrb_q;
    assign wlast  = wlast_q;
    assign wvalid = wvalid_q;

    assign bready = bready_q;

endmodule

// File: tb/tb_cl_memdut_scrubber.sv
`timescale 1ns/1ps
// Bench for cl_memdut_scrubber: directed steps in one initial block, an
// AXI slave/monitor process with a scoreboard of expected AW addresses and
// per-beat wlast values.
module tb_cl_memdut_scrubber;

    localparam logic [63:0] MEM_BASE  = 64'h0;
    localparam logic [63:0] MEM_SIZE  = 64'h1000;
    localparam int          BURST_LEN = 16;
    localparam logic [15:0] SCRB_ID   = 16'hA5C3;
    localparam logic [63:0] BBYTES    = 64'h400;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         scrb_enable;
    logic [63:0]  scrb_addr;
    logic [2:0]   scrb_state;
    logic         scrb_done;
    logic [15:0]  scrb_err_cnt;
    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [15:0]  wid;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    always #5 clk = ~clk;

    cl_memdut_scrubber #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE),
        .BURST_LEN(BURST_LEN),
        .SCRB_ID  (SCRB_ID)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scrb_enable(scrb_enable),
        .scrb_addr(scrb_addr), .scrb_state(scrb_state), .scrb_done(scrb_done),
        .scrb_err_cnt(scrb_err_cnt),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_aw[$];
    bit          exp_wl[$];
    bit          stall;
    logic [7:0]  err_mask;
    int          b_idx;
    int          beats_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected transactions for nb bursts from MEM_BASE
    task automatic push_run(input int nb);
        for (int b = 0; b < nb; b++) begin
            exp_aw.push_back(MEM_BASE + 64'(b) * BBYTES);
            for (int i = 0; i < BURST_LEN; i++) exp_wl.push_back(i == BURST_LEN - 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, scrb_state, 0);
        chk({tag, "_addr"}, scrb_addr, 0);
        chk({tag, "_done"}, scrb_done, 0);
        chk({tag, "_err"}, scrb_err_cnt, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_awlen"}, awlen, 0);
        chk({tag, "_awsize"}, awsize, 0);
        chk({tag, "_awid"}, awid, 0);
        chk({tag, "_wid"}, wid, 0);
        chk({tag, "_wstrb"}, wstrb, 0);
        chk({tag, "_wdata_zero"}, wdata == '0, 1);
    endtask

    // Called at a negedge; returns at a negedge
    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (scrb_state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reached"}, scrb_state, st);
    endtask

    task automatic wait_beats(input string tag, input int nb, input int budget);
        int n = 0;
        while (beats_seen < nb && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_beats_reached"}, beats_seen >= nb, 1);
    endtask

    task automatic start_run(input string tag, input int nb);
        push_run(nb);
        b_idx = 0;
        beats_seen = 0;
        @(posedge clk); #1;
        scrb_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_start_awvalid"}, awvalid, 1);
        chk({tag, "_start_awaddr"}, awaddr, MEM_BASE);
        chk({tag, "_start_errcnt"}, scrb_err_cnt, 0);
    endtask

    task automatic drained(input string tag);
        chk({tag, "_aw_left"}, exp_aw.size(), 0);
        chk({tag, "_w_left"}, exp_wl.size(), 0);
    endtask

    task automatic finish_run(input string tag);
        chk({tag, "_done"}, scrb_done, 1);
        chk({tag, "_done_addr"}, scrb_addr, MEM_BASE + MEM_SIZE);
        drained(tag);
        @(posedge clk); #1;
        scrb_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_off_state"}, scrb_state, ST_IDLE);
        chk({tag, "_off_done"}, scrb_done, 0);
    endtask

    // AXI slave model and channel monitor
    initial begin
        bit aw_done, b_pending, aw_hs, w_hs, b_hs;
        bit p_aw_stall, p_w_stall, p_b_stall, p_wlast;
        logic [63:0] p_awaddr;
        aw_done = 0; b_pending = 0; b_hs = 0;
        p_aw_stall = 0; p_w_stall = 0; p_b_stall = 0; p_wlast = 0; p_awaddr = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 16'h0;
        forever begin
            @(negedge clk);
            aw_hs = 0; w_hs = 0; b_hs = 0;
            if (!rst_n) begin
                aw_done = 0; b_pending = 0;
                p_aw_stall = 0; p_w_stall = 0; p_b_stall = 0;
            end else begin
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                b_hs  = bvalid && bready;
                if (p_aw_stall) begin
                    chk("aw_hold_valid", awvalid, 1);
                    chk("aw_hold_addr", awaddr, p_awaddr);
                end
                if (p_w_stall) begin
                    chk("w_hold_valid", wvalid, 1);
                    chk("w_hold_last", wlast, p_wlast);
                end
                if (p_b_stall) chk("b_hold_ready", bready, 1);
                if (wvalid) chk("w_after_aw", aw_done, 1);
                if (aw_hs) begin
                    chk("aw_expected", exp_aw.size() != 0, 1);
                    if (exp_aw.size() != 0) chk("awaddr", awaddr, exp_aw.pop_front());
                    chk("awlen", awlen, BURST_LEN - 1);
                    chk("awsize", awsize, 6);
                    chk("awid", awid, SCRB_ID);
                    aw_done = 1;
                end
                if (w_hs) begin
                    chk("w_expected", exp_wl.size() != 0, 1);
                    if (exp_wl.size() != 0) chk("wlast", wlast, exp_wl.pop_front());
                    chk("wdata_zero", wdata == '0, 1);
                    chk("wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
                    chk("wid", wid, SCRB_ID);
                    beats_seen++;
                    if (wlast) begin
                        aw_done = 0;
                        b_pending = 1;
                    end
                end
                if (b_hs) b_idx++;
                p_aw_stall = awvalid && !awready;
                p_awaddr   = awaddr;
                p_w_stall  = wvalid && !wready;
                p_wlast    = wlast;
                p_b_stall  = bready && !bvalid;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            end else begin
                awready = awvalid && (!stall || $urandom_range(0, 3) == 0);
                wready  = wvalid && (!stall || $urandom_range(0, 3) == 0);
                bid     = 16'($urandom_range(0, 65535));
                if (b_hs) begin
                    bvalid = 1'b0;
                end else if (b_pending && !bvalid && (!stall || $urandom_range(0, 3) == 0)) begin
                    bvalid    = 1'b1;
                    bresp     = (b_idx < 8 && err_mask[b_idx]) ? 2'b10 : 2'b00;
                    b_pending = 0;
                end
            end
        end
    end

    // Directed sequence
    initial begin
        stall = 0; err_mask = 8'h00; b_idx = 0; beats_seen = 0;
        rst_n = 1'b0; scrb_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_enable_state", scrb_state, ST_IDLE);
        chk("idle_no_enable_awvalid", awvalid, 0);

        // Basic scrub, then hold enable after done
        start_run("basic", 4);
        wait_state("basic", ST_DONE, 500);
        for (int i = 0; i < 10; i++) begin
            chk("done_hold_done", scrb_done, 1);
            chk("done_hold_state", scrb_state, ST_DONE);
            chk("done_hold_awvalid", awvalid, 0);
            chk("done_hold_wvalid", wvalid, 0);
            @(negedge clk);
        end
        chk("basic_err", scrb_err_cnt, 0);
        finish_run("basic");

        // Backpressure on all three channels
        stall = 1;
        start_run("bp", 4);
        wait_state("bp", ST_DONE, 3000);
        finish_run("bp");
        stall = 0;

        // Error responses on bursts 2 and 3
        err_mask = 8'b0000_0110;
        start_run("err", 4);
        wait_state("err", ST_DONE, 500);
        chk("err_cnt_two", scrb_err_cnt, 2);
        finish_run("err");
        chk("err_cnt_kept_idle", scrb_err_cnt, 2);
        err_mask = 8'h00;
        start_run("reerr", 4);
        wait_state("reerr", ST_DONE, 500);
        chk("reerr_cnt_zero", scrb_err_cnt, 0);
        finish_run("reerr");

        // Abort during beat 5 of the burst at 0x400
        start_run("abort", 2);
        wait_beats("abort", BURST_LEN + 5, 200);
        @(posedge clk); #1;
        scrb_enable = 1'b0;
        @(negedge clk);
        wait_state("abort_idle", ST_IDLE, 300);
        chk("abort_addr", scrb_addr, 64'h800);
        chk("abort_done", scrb_done, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_aw", awvalid, 0);
        end
        drained("abort");

        // Reset in the middle of a data burst
        start_run("rstmid", 4);
        wait_beats("rstmid", 3, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        exp_aw.delete();
        exp_wl.delete();
        repeat (2) @(posedge clk);
        #1;
        push_run(4);
        b_idx = 0;
        beats_seen = 0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_awvalid", awvalid, 1);
        chk("restart_awaddr", awaddr, MEM_BASE);
        wait_state("restart", ST_DONE, 500);
        finish_run("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
